wide_add_sequencer: RTL
=======================

// Module: wide_add_sequencer
// PURPOSE
//   Multi-cycle controller that adds two WORDS*WIDTH-bit operands with a single
//   WIDTH-bit RCA adder, one WIDTH-bit chunk per cycle, LSB chunk first.
//   Registers the inter-chunk carry, assembles the wide sum and hands it off on
//   a valid/ready pair. Sits between a wide-operand producer and consumer so
//   one narrow prefix/ripple adder serves arbitrarily wide additions.
// PARAMETERS
//   WIDTH    16  chunk width, equal to the adder width
//   VALENCY  2   passed unchanged to the RCA instance
//   WORDS    4   chunks per operation; legal range >= 1; total width N = WORDS*WIDTH
// PORTS
//   clk        in   1  single clock, all state updates on rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  request carries a valid operand pair
//   in_ready   out  1  block accepts a request this cycle
//   in_a       in   N  operand A
//   in_b       in   N  operand B
//   in_cin     in   1  carry-in into chunk 0
//   out_valid  out  1  out_sum/out_cout valid
//   out_ready  in   1  consumer takes the result this cycle
//   out_sum    out  N  (A + B + Cin) mod 2^N
//   out_cout   out  1  carry out of the top chunk
//   busy       out  1  high in RUN or DONE
// BEHAVIOUR
//   - FSM states: IDLE, RUN, DONE. Reset -> IDLE, idx=0, carry=0, result=0.
//   - Reset values: in_ready=0 while rst high, 1 in the first cycle after; out_valid=0,
//     out_sum=0, out_cout=0, busy=0.
//   - IDLE: in_ready=1. On in_valid&&in_ready: capture in_a, in_b into operand regs,
//     carry<=in_cin, idx<=0, go to RUN. Inputs may change after the accept cycle.
//   - RUN: in_ready=0. Adder A/B = chunk idx of operand regs, Cin = carry reg.
//     Each cycle: result[idx] <= adder S; carry <= adder Cout; idx <= idx+1.
//     When idx==WORDS-1: go to DONE, out_cout <= adder Cout, idx <= 0.
//   - DONE: out_valid=1, out_sum/out_cout held stable. Stay until out_ready;
//     on out_valid&&out_ready go to IDLE (out_valid drops next cycle).
//   - Latency: accept in cycle t -> RUN cycles t+1..t+WORDS -> out_valid first high
//     in cycle t+WORDS+1. No overlap: max throughput one op per WORDS+2 cycles.
//   - in_ready is a decode of state (and !rst), never depends on in_valid in the same cycle.
//   - WORDS=1: RUN lasts exactly one cycle; idx register degenerates to 1 bit, always 0.
//   - Carry chain across chunks is exact: result equals full-width binary sum;
//     overflow beyond N bits appears only on out_cout.
//   - Backpressure: out_ready low in DONE holds all outputs unchanged indefinitely.
//   - rst mid-operation (RUN or DONE): next cycle IDLE, result discarded, outputs at reset
//     values; no partial result ever shows out_valid.
//   - in_valid while RUN/DONE is ignored (not accepted, not queued).
// STRUCTURE
//   - Package add_seq_pkg: state enum {IDLE, RUN, DONE}; function idx_w(WORDS) =
//     max(1, clog2(WORDS)); chunk-select helper.
//   - One sub-module: the existing RCA adder (WIDTH, VALENCY), instantiated once,
//     combinational; all registers (operands, result, carry, idx, state) live here.
//   - Chunk select by idx via indexed part-select; result written per chunk.
// TESTING (WIDTH=16, WORDS=4 unless noted)
//   1. a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> out_sum=0, out_cout=1, out_valid at t+5.
//   2. a=0x0001_0002_0003_0004, b=0x0010_0020_0030_0040, cin=1
//      -> out_sum=0x0011_0022_0033_0045, out_cout=0.
//   3. Case 2 with out_ready low 10 cycles -> out_valid, out_sum stable, in_ready=0,
//      new in_valid ignored; completes when out_ready rises.
//   4. rst pulse in 2nd RUN cycle -> next cycle IDLE, out_valid=0, out_sum=0;
//      following op (case 1) still correct.
//   5. in_valid and out_ready tied high, operands changed every accept -> accepts exactly
//      every 6 cycles; each result matches a golden 64-bit sum including cout.
//   6. WORDS=1 build: a=0xFFFF, b=0x0001, cin=1 -> out_sum=0x0001, out_cout=1, out_valid at t+2.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the chunked wide-add sequencer.
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the chunk index register; never narrower than one bit.
   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   // Bit offset of chunk 'idx' inside a wide operand of 'width'-bit chunks.
   function automatic int chunk_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_rca.sv
// Narrow combinational adder: VALENCY-bit blocks chained by a ripple carry.
module wide_add_sequencer_rca #(
   parameter int WIDTH   = 16,
   parameter int VALENCY = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int GROUP = (VALENCY < 1) ? 1 : VALENCY;
   localparam int NG    = (WIDTH + GROUP - 1) / GROUP;
   localparam int PW    = NG * GROUP;

   logic [PW-1:0] a_pad;
   logic [PW-1:0] b_pad;
   logic [PW-1:0] sum_pad;
   logic          carry;

   assign a_pad = PW'(a);
   assign b_pad = PW'(b);

   // Ripple the carry through each VALENCY-bit block, LSB block first.
   always_comb begin
      carry   = cin;
      sum_pad = '0;
      for (int g = 0; g < NG; g++) begin
         {carry, sum_pad[g*GROUP +: GROUP]} = {1'b0, a_pad[g*GROUP +: GROUP]}
                                            + {1'b0, b_pad[g*GROUP +: GROUP]}
                                            + (GROUP+1)'(carry);
      end
   end

   assign sum = sum_pad[WIDTH-1:0];

   // A partial top block leaves its carry in the first zero-padded bit.
   if (PW == WIDTH) begin : g_exact
      assign cout = carry;
   end else begin : g_padded
      assign cout = sum_pad[WIDTH];
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two WORDS*WIDTH-bit operands one WIDTH-bit chunk per cycle through a
// single narrow adder, then holds the wide sum on a valid/ready output.
module wide_add_sequencer
   import add_seq_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int VALENCY = 2,
   parameter int WORDS   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORDS*WIDTH-1:0] in_a,
   input  logic [WORDS*WIDTH-1:0] in_b,
   input  logic                   in_cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORDS*WIDTH-1:0] out_sum,
   output logic                   out_cout,
   output logic                   busy
);

   localparam int              N        = WORDS * WIDTH;
   localparam int              IW       = idx_w(WORDS);
   localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);

   state_e         state_q,  state_d;
   logic [IW-1:0]  idx_q,    idx_d;
   logic           carry_q,  carry_d;
   logic [N-1:0]   op_a_q,   op_a_d;
   logic [N-1:0]   op_b_q,   op_b_d;
   logic [N-1:0]   result_q, result_d;
   logic           cout_q,   cout_d;

   logic [WIDTH-1:0] chunk_a;
   logic [WIDTH-1:0] chunk_b;
   logic [WIDTH-1:0] chunk_s;
   logic             chunk_cout;

   assign chunk_a = op_a_q[chunk_lo(int'(idx_q), WIDTH) +: WIDTH];
   assign chunk_b = op_b_q[chunk_lo(int'(idx_q), WIDTH) +: WIDTH];

   wide_add_sequencer_rca #(
      .WIDTH   (WIDTH),
      .VALENCY (VALENCY)
   ) u_rca (
      .a    (chunk_a),
      .b    (chunk_b),
      .cin  (carry_q),
      .sum  (chunk_s),
      .cout (chunk_cout)
   );

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_sum   = result_q;
   assign out_cout  = cout_q;

   // Next-state: accept in IDLE, one chunk per RUN cycle, hold in DONE until taken.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      result_d = result_q;
      cout_d   = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_a_d  = in_a;
               op_b_d  = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[chunk_lo(int'(idx_q), WIDTH) +: WIDTH] = chunk_s;
            carry_d = chunk_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = chunk_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
      end
   end

endmodule
